layer_sequencer: RTL and testbench
==================================

// Module: layer_sequencer
// PURPOSE
//  Per-sample controller for the SNN `layer` datapath. Accepts one encoded input sample (spike times
//  for `num_spikes` inputs) over a valid/ready handshake, clears the layer, sweeps time_val 0..TIME_PERIOD-1,
//  captures the first winning neuron and its spike time, and returns the result over a valid/ready handshake.
//  Sits between the sample source (file/stream loader) and the result sink (classifier/logger).
// PARAMETERS
//  NUM_SPIKES   default `num_spikes          number of input synapses per sample
//  NUM_NEURONS  default `neurons_per_layer   neurons in the driven layer
//  TIME_PERIOD  default `time_period         time steps per sample (>=2)
//  EARLY_EXIT   default 1                    1: stop sweep at first output spike; 0: always full sweep
// PORTS
//  clk               in   1                          clock
//  rst               in   1                          synchronous reset, active-high
//  in_valid          in   1                          sample available
//  in_ready          out  1                          sequencer accepts sample this cycle
//  in_spike_times    in   NUM_SPIKES x TBITS         sample spike times (value >= TIME_PERIOD = no spike)
//  spike_times       out  NUM_SPIKES x TBITS         registered sample driven to layer, held for whole sweep
//  time_val          out  TBITS                      current time step driven to layer
//  layer_clear       out  1                          one-cycle pulse resetting layer potentials
//  winning_neuron    in   NBITS                      from layer
//  output_spike_time in   TBITS                      from layer; >= TIME_PERIOD means no spike yet
//  out_valid         out  1                          result available
//  out_ready         in   1                          sink accepts result
//  out_winner        out  NBITS                      captured winner (0 if none)
//  out_time          out  TBITS                      captured spike time (TIME_PERIOD if none)
//  out_none          out  1                          no neuron fired during sweep
// BEHAVIOUR
//  - TBITS = $clog2(TIME_PERIOD)+1; NBITS = $clog2(NUM_NEURONS). All time compares unsigned.
//  - States: IDLE -> CLEAR -> RUN -> DONE -> IDLE (+ LEARN under macro).
//  - Reset (rst=1 at clk edge): state IDLE, in_ready 0 then 1 in IDLE, time_val 0, spike_times all TIME_PERIOD,
//    layer_clear 0, out_valid 0, out_winner 0, out_time TIME_PERIOD, out_none 0. Reset mid-sweep aborts, no result.
//  - IDLE: in_ready=1. Transfer on in_valid&&in_ready: latch in_spike_times, go CLEAR.
//  - CLEAR: layer_clear=1 for exactly one cycle, time_val=0; next RUN.
//  - RUN: time_val increments by 1 per cycle from 0. Fire = output_spike_time < TIME_PERIOD; on first fire latch
//    winning_neuron/output_spike_time (later fires ignored). Leave RUN after the cycle time_val==TIME_PERIOD-1,
//    or (EARLY_EXIT=1) the cycle after first fire. Fire and last step in same cycle: captured, then DONE.
//  - DONE: out_valid=1, outputs stable until out_valid&&out_ready; then IDLE. in_ready=0 outside IDLE.
//  - No fire: out_none=1, out_winner=0, out_time=TIME_PERIOD.
//  - Latency accept->out_valid: TIME_PERIOD+2 cycles (full sweep); fire_time+3 with EARLY_EXIT.
//  - time_val never exceeds TIME_PERIOD-1 (no wrap); holds last value in DONE.
// CONFIGURATION
//  LAYER_SEQ_LEARN_EN defined: adds ports learn_en (out,1) and learn_neuron (out,NBITS). After RUN, if a neuron
//    fired, state LEARN asserts learn_en for 1 cycle with learn_neuron=captured winner, before DONE (latency +1).
//    No fire: LEARN skipped. learn_en reset 0.
//  Undefined: no learn ports, no LEARN state, timing as above.
// STRUCTURE
//  - Package layer_seq_pkg: state enum (IDLE, CLEAR, RUN, LEARN, DONE), TBITS/NBITS localparam functions,
//    NO_SPIKE constant (=TIME_PERIOD), result struct {winner, time, none}.
//  - Sub-module layer_seq_capture: first-fire detector/latch (clear, fire, winner, time -> held result).
//  - Top: FSM, time counter, input sample register, handshakes.
// TESTING
//  - Reset: rst high 3 cycles mid-RUN -> IDLE, in_ready=1 next cycle, out_valid never asserted, time_val=0.
//  - Single fire, TIME_PERIOD=8, EARLY_EXIT=0: layer model fires neuron 3 at t=4 -> out_winner=3, out_time=4,
//    out_valid 10 cycles after accept.
//  - EARLY_EXIT=1, fire at t=2 -> out_valid 5 cycles after accept; time_val stops at 2.
//  - No fire over full sweep -> out_none=1, out_winner=0, out_time=8.
//  - Backpressure: out_ready low 6 cycles -> outputs stable, in_ready=0, next sample accepted only after handshake.
//  - Fire at t=7 (last step) and second fire t=7 on neuron 1 after neuron 5 at t=5 -> capture first only (5,5);
//    with LAYER_SEQ_LEARN_EN: one learn_en pulse, learn_neuron=5, then DONE.

Source files
------------

// File: rtl/layer_seq_pkg.sv
// layer_seq_pkg: shared types, width helpers and defaults for the SNN layer sequencer.
// Optional feature macro used by the sequencer: LAYER_SEQ_LEARN_EN (adds a LEARN state and learn ports).
// The SNN-wide macros (SNN_NUM_SPIKES, SNN_NEURONS_PER_LAYER, SNN_TIME_PERIOD) get fallback values here
// so the sequencer can be built stand-alone.
`ifndef SNN_NUM_SPIKES
`define SNN_NUM_SPIKES 4
`endif
`ifndef SNN_NEURONS_PER_LAYER
`define SNN_NEURONS_PER_LAYER 8
`endif
`ifndef SNN_TIME_PERIOD
`define SNN_TIME_PERIOD 8
`endif

package layer_seq_pkg;

  // Sequencer states; LEARN is only reachable when LAYER_SEQ_LEARN_EN is defined.
  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    LEARN,
    DONE
  } state_t;

  // Time values need one extra bit so TIME_PERIOD itself ("no spike") is representable.
  function automatic int tbits(input int time_period);
    return $clog2(time_period) + 1;
  endfunction

  // Neuron index width; a single-neuron layer still gets a 1-bit index.
  function automatic int nbits(input int num_neurons);
    return (num_neurons > 1) ? $clog2(num_neurons) : 1;
  endfunction

  // Default-build sentinel meaning "no spike"; modules derive their own from TIME_PERIOD.
  localparam int NO_SPIKE  = `SNN_TIME_PERIOD;
  localparam int DEF_TBITS = tbits(`SNN_TIME_PERIOD);
  localparam int DEF_NBITS = nbits(`SNN_NEURONS_PER_LAYER);

  // Per-sample result record for the default layer geometry.
  typedef struct packed {
    logic [DEF_NBITS-1:0] winner;
    logic [DEF_TBITS-1:0] spike_time;
    logic                 none;
  } result_t;

endpackage

// File: rtl/layer_seq_capture.sv
// layer_seq_capture: first-fire detector and latch for one sample sweep.
// A fire is any output_spike_time below TIME_PERIOD; only the first one after a clear is kept.
module layer_seq_capture
  import layer_seq_pkg::*;
#(
  parameter int TIME_PERIOD = `SNN_TIME_PERIOD,
  parameter int NUM_NEURONS = `SNN_NEURONS_PER_LAYER
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clear,
  input  logic                             enable,
  input  logic [nbits(NUM_NEURONS)-1:0]    winner_in,
  input  logic [tbits(TIME_PERIOD)-1:0]    time_in,
  output logic                             fire,
  output logic                             captured,
  output logic [nbits(NUM_NEURONS)-1:0]    winner,
  output logic [tbits(TIME_PERIOD)-1:0]    spike_time
);

  localparam int TBITS = tbits(TIME_PERIOD);
  localparam int NBITS = nbits(NUM_NEURONS);
  localparam logic [TBITS-1:0] NO_SPIKE_T = TBITS'(TIME_PERIOD);

  logic             captured_q, captured_d;
  logic [NBITS-1:0] winner_q, winner_d;
  logic [TBITS-1:0] time_q, time_d;

  assign fire       = (time_in < NO_SPIKE_T);
  assign captured   = captured_q;
  assign winner     = winner_q;
  assign spike_time = time_q;

  // Clear restores the "nothing seen" result; otherwise latch only the first enabled fire.
  always_comb begin
    captured_d = captured_q;
    winner_d   = winner_q;
    time_d     = time_q;
    if (clear) begin
      captured_d = 1'b0;
      winner_d   = '0;
      time_d     = NO_SPIKE_T;
    end else if (enable && fire && !captured_q) begin
      captured_d = 1'b1;
      winner_d   = winner_in;
      time_d     = time_in;
    end
  end

  // Result registers with synchronous reset to the "no spike" result.
  always_ff @(posedge clk) begin
    if (rst) begin
      captured_q <= 1'b0;
      winner_q   <= '0;
      time_q     <= NO_SPIKE_T;
    end else begin
      captured_q <= captured_d;
      winner_q   <= winner_d;
      time_q     <= time_d;
    end
  end

endmodule

// File: rtl/layer_sequencer.sv
// layer_sequencer: per-sample controller for the SNN layer datapath.
// Accepts a sample, pulses layer_clear, sweeps time_val 0..TIME_PERIOD-1, captures the first
// winner and hands the result to the sink. Define LAYER_SEQ_LEARN_EN to add a one-cycle LEARN
// pulse (learn_en/learn_neuron) between the sweep and the result when a neuron fired.
module layer_sequencer
  import layer_seq_pkg::*;
#(
  parameter int NUM_SPIKES  = `SNN_NUM_SPIKES,
  parameter int NUM_NEURONS = `SNN_NEURONS_PER_LAYER,
  parameter int TIME_PERIOD = `SNN_TIME_PERIOD,
  parameter int EARLY_EXIT  = 1
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic [NUM_SPIKES-1:0][tbits(TIME_PERIOD)-1:0] in_spike_times,
  output logic [NUM_SPIKES-1:0][tbits(TIME_PERIOD)-1:0] spike_times,
  output logic [tbits(TIME_PERIOD)-1:0]                 time_val,
  output logic                                          layer_clear,
  input  logic [nbits(NUM_NEURONS)-1:0]                 winning_neuron,
  input  logic [tbits(TIME_PERIOD)-1:0]                 output_spike_time,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [nbits(NUM_NEURONS)-1:0]                 out_winner,
  output logic [tbits(TIME_PERIOD)-1:0]                 out_time,
  output logic                                          out_none
`ifdef LAYER_SEQ_LEARN_EN
  ,
  output logic                                          learn_en,
  output logic [nbits(NUM_NEURONS)-1:0]                 learn_neuron
`endif
);

  localparam int TBITS = tbits(TIME_PERIOD);
  localparam int NBITS = nbits(NUM_NEURONS);
  localparam logic [TBITS-1:0] NO_SPIKE_T = TBITS'(TIME_PERIOD);
  localparam logic [TBITS-1:0] LAST_T     = TBITS'(TIME_PERIOD - 1);
  localparam bit               EARLY      = (EARLY_EXIT != 0);

  state_t                           state_q, state_d;
  logic                             in_ready_q, in_ready_d;
  logic [TBITS-1:0]                 time_q, time_d;
  logic [NUM_SPIKES-1:0][TBITS-1:0] spikes_q, spikes_d;
  logic                             sweep_end_q, sweep_end_d;

  logic             fire;
  logic             captured;
  logic [NBITS-1:0] cap_winner;
  logic [TBITS-1:0] cap_time;
  logic             hold_time;
  logic             sweep_exit;
  state_t           after_run;

  layer_seq_capture #(
    .TIME_PERIOD (TIME_PERIOD),
    .NUM_NEURONS (NUM_NEURONS)
  ) u_capture (
    .clk        (clk),
    .rst        (rst),
    .clear      (state_q == CLEAR),
    .enable     (state_q == RUN),
    .winner_in  (winning_neuron),
    .time_in    (output_spike_time),
    .fire       (fire),
    .captured   (captured),
    .winner     (cap_winner),
    .spike_time (cap_time)
  );

  // With early exit the clock stops on the fire step and the sweep ends one cycle later;
  // otherwise the sweep ends one cycle after the last time step has been presented.
  assign hold_time  = EARLY && (fire || captured);
  assign sweep_exit = sweep_end_q || (EARLY && captured);

`ifdef LAYER_SEQ_LEARN_EN
  assign after_run = captured ? LEARN : DONE;
`else
  assign after_run = DONE;
`endif

  // Next-state logic: handshakes, time counter and the held input sample.
  always_comb begin
    state_d     = state_q;
    time_d      = time_q;
    spikes_d    = spikes_q;
    sweep_end_d = sweep_end_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          spikes_d    = in_spike_times;
          time_d      = '0;
          sweep_end_d = 1'b0;
          state_d     = CLEAR;
        end
      end
      CLEAR: begin
        time_d      = '0;
        sweep_end_d = 1'b0;
        state_d     = RUN;
      end
      RUN: begin
        if (time_q == LAST_T) begin
          sweep_end_d = 1'b1;
        end else if (!hold_time) begin
          time_d = time_q + TBITS'(1);
        end
        if (sweep_exit) begin
          state_d = after_run;
        end
      end
      LEARN: begin
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    in_ready_d = (state_d == IDLE);
  end

  // Control registers; reset aborts any sweep in progress without producing a result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      time_q      <= '0;
      spikes_q    <= {NUM_SPIKES{NO_SPIKE_T}};
      sweep_end_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      time_q      <= time_d;
      spikes_q    <= spikes_d;
      sweep_end_q <= sweep_end_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign spike_times = spikes_q;
  assign time_val    = time_q;
  assign layer_clear = (state_q == CLEAR);
  assign out_valid   = (state_q == DONE);
  assign out_winner  = cap_winner;
  assign out_time    = cap_time;
  assign out_none    = (state_q == DONE) && !captured;

`ifdef LAYER_SEQ_LEARN_EN
  assign learn_en     = (state_q == LEARN);
  assign learn_neuron = cap_winner;
`endif

endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer: directed scoreboard bench for layer_sequencer.
// Two instances (EARLY_EXIT=0 and EARLY_EXIT=1, TIME_PERIOD=8) each drive a small layer model
// that fires on a per-sample schedule. Honours LAYER_SEQ_LEARN_EN when defined.
module tb_layer_sequencer;

  localparam int TP = 8;
`ifdef LAYER_SEQ_LEARN_EN
  localparam int LEARN_LAT = 1;
`else
  localparam int LEARN_LAT = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst;
  logic [1:0]            in_valid;
  logic [1:0]            in_ready;
  logic [1:0][3:0][3:0]  in_spk;
  logic [1:0][3:0][3:0]  spk;
  logic [1:0][3:0]       time_val;
  logic [1:0]            layer_clear;
  logic [1:0][2:0]       win_n;
  logic [1:0][3:0]       ost;
  logic [1:0]            out_valid;
  logic [1:0]            out_ready;
  logic [1:0][2:0]       out_winner;
  logic [1:0][3:0]       out_time;
  logic [1:0]            out_none;
`ifdef LAYER_SEQ_LEARN_EN
  logic [1:0]            learn_en;
  logic [1:0][2:0]       learn_neuron;
  int                    learn_cnt [2];
  int                    learn_last [2];
`endif

  // Layer model schedule: neuron first_n fires at first_t, then neuron second_n reports at second_t.
  int first_t [2];
  int first_n [2];
  int second_t [2];
  int second_n [2];

  int cyc;
  int clear_cnt [2];
  int total;
  int bad;

  typedef struct {
    int               e;
    int               winner;
    int               t;
    int               none;
    int               lat;
    int               tv;
    int               acc;
    int               clr_base;
    int               learn;
    int               learn_base;
    logic [15:0]      spk;
  } exp_t;

  exp_t sb [$];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    layer_sequencer #(
      .NUM_SPIKES  (4),
      .NUM_NEURONS (8),
      .TIME_PERIOD (TP),
      .EARLY_EXIT  (g)
    ) dut (
      .clk               (clk),
      .rst               (rst),
      .in_valid          (in_valid[g]),
      .in_ready          (in_ready[g]),
      .in_spike_times    (in_spk[g]),
      .spike_times       (spk[g]),
      .time_val          (time_val[g]),
      .layer_clear       (layer_clear[g]),
      .winning_neuron    (win_n[g]),
      .output_spike_time (ost[g]),
      .out_valid         (out_valid[g]),
      .out_ready         (out_ready[g]),
      .out_winner        (out_winner[g]),
      .out_time          (out_time[g]),
      .out_none          (out_none[g])
`ifdef LAYER_SEQ_LEARN_EN
      ,
      .learn_en          (learn_en[g]),
      .learn_neuron      (learn_neuron[g])
`endif
    );
  end

  // Layer model: once time_val reaches a scheduled fire time the layer reports that spike.
  always_comb begin
    for (int e = 0; e < 2; e++) begin
      ost[e]   = 4'(TP);
      win_n[e] = 3'd0;
      if (first_t[e] < TP && int'(time_val[e]) >= first_t[e]) begin
        ost[e]   = 4'(first_t[e]);
        win_n[e] = 3'(first_n[e]);
      end
      if (second_t[e] < TP && int'(time_val[e]) >= second_t[e]) begin
        ost[e]   = 4'(second_t[e]);
        win_n[e] = 3'(second_n[e]);
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse counters sampled away from the active edge.
  always @(negedge clk) begin
    for (int e = 0; e < 2; e++) begin
      if (layer_clear[e]) clear_cnt[e]++;
`ifdef LAYER_SEQ_LEARN_EN
      if (learn_en[e]) begin
        learn_cnt[e]++;
        learn_last[e] = int'(learn_neuron[e]);
      end
`endif
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached, observed=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Drive one sample on instance e with the given fire schedule; push the expected result.
  task automatic applyStimulus(input int e, input int ft, input int fn, input int st, input int sn,
                               input logic [15:0] sample, input bit push);
    exp_t ex;
    int   n;
    int   tf;
    int   w;
    first_t[e]  = ft;
    first_n[e]  = fn;
    second_t[e] = st;
    second_n[e] = sn;
    in_spk[e]   = sample;
    in_valid[e] = 1'b1;
    n = 0;
    while (!in_ready[e] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready[e]) begin
      checkValue("accept_timeout", 32'(in_ready[e]), 32'd1);
      in_valid[e] = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid[e] = 1'b0;
    if (push) begin
      tf = -1;
      w  = 0;
      if (ft < TP) begin
        tf = ft;
        w  = fn;
      end else if (st < TP) begin
        tf = st;
        w  = sn;
      end
      ex.e          = e;
      ex.none       = (tf < 0) ? 1 : 0;
      ex.winner     = (tf < 0) ? 0 : w;
      ex.t          = (tf < 0) ? TP : tf;
      ex.lat        = ((tf >= 0) && (e == 1)) ? tf + 3 : TP + 2;
      ex.lat       += (tf >= 0) ? LEARN_LAT : 0;
      ex.tv         = ((tf >= 0) && (e == 1)) ? tf : TP - 1;
      ex.acc        = cyc;
      ex.clr_base   = clear_cnt[e];
      ex.learn      = (tf >= 0) ? 1 : 0;
`ifdef LAYER_SEQ_LEARN_EN
      ex.learn_base = learn_cnt[e];
`else
      ex.learn_base = 0;
`endif
      ex.spk        = sample;
      sb.push_back(ex);
    end
  endtask

  // Wait for the result on instance e, compare against the scoreboard, optionally backpressure.
  task automatic checkOutput(input int e, input int hold);
    exp_t ex;
    int   n;
    n = 0;
    while (!out_valid[e] && n < 60) begin
      @(negedge clk);
      n++;
    end
    checkValue("out_valid_seen", 32'(out_valid[e]), 32'd1);
    if (!out_valid[e] || sb.size() == 0) begin
      if (sb.size() != 0) void'(sb.pop_front());
      out_ready[e] = 1'b1;
      return;
    end
    ex = sb.pop_front();
    checkValue("latency",     32'(cyc - ex.acc),       32'(ex.lat));
    checkValue("out_winner",  32'(out_winner[e]),      32'(ex.winner));
    checkValue("out_time",    32'(out_time[e]),        32'(ex.t));
    checkValue("out_none",    32'(out_none[e]),        32'(ex.none));
    checkValue("time_val",    32'(time_val[e]),        32'(ex.tv));
    checkValue("spike_times", 32'(spk[e]),             32'(ex.spk));
    checkValue("clear_pulse", 32'(clear_cnt[e] - ex.clr_base), 32'd1);
    checkValue("in_ready_busy", 32'(in_ready[e]),      32'd0);
`ifdef LAYER_SEQ_LEARN_EN
    checkValue("learn_pulses", 32'(learn_cnt[e] - ex.learn_base), 32'(ex.learn));
    if (ex.learn != 0) checkValue("learn_neuron", 32'(learn_last[e]), 32'(ex.winner));
`endif
    if (hold > 0) begin
      in_valid[e] = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        checkValue("hold_valid",  32'(out_valid[e]),  32'd1);
        checkValue("hold_winner", 32'(out_winner[e]), 32'(ex.winner));
        checkValue("hold_time",   32'(out_time[e]),   32'(ex.t));
        checkValue("hold_ready",  32'(in_ready[e]),   32'd0);
      end
      out_ready[e] = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    checkValue("valid_drop", 32'(out_valid[e]), 32'd0);
    checkValue("ready_back", 32'(in_ready[e]),  32'd1);
  endtask

  initial begin
    int ones;
    rst       = 1'b1;
    in_valid  = '0;
    out_ready = '1;
    in_spk    = '0;
    for (int e = 0; e < 2; e++) begin
      first_t[e]  = 99;
      first_n[e]  = 0;
      second_t[e] = 99;
      second_n[e] = 0;
    end
    $display("[TB] reset checks");
    repeat (3) @(negedge clk);
    checkValue("rst_in_ready0", 32'(in_ready[0]), 32'd0);
    checkValue("rst_in_ready1", 32'(in_ready[1]), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    for (int e = 0; e < 2; e++) begin
      checkValue("rst_in_ready",    32'(in_ready[e]),    32'd1);
      checkValue("rst_out_valid",   32'(out_valid[e]),   32'd0);
      checkValue("rst_out_winner",  32'(out_winner[e]),  32'd0);
      checkValue("rst_out_time",    32'(out_time[e]),    32'd8);
      checkValue("rst_out_none",    32'(out_none[e]),    32'd0);
      checkValue("rst_time_val",    32'(time_val[e]),    32'd0);
      checkValue("rst_layer_clear", 32'(layer_clear[e]), 32'd0);
      checkValue("rst_spike_times", 32'(spk[e]),         32'h8888);
    end

    $display("[TB] full sweep, single fire");
    applyStimulus(0, 4, 3, 99, 0, 16'h1234, 1'b1);
    checkOutput(0, 0);

    $display("[TB] early exit, fire at t=2");
    applyStimulus(1, 2, 6, 99, 0, 16'h0F21, 1'b1);
    checkOutput(1, 0);

    $display("[TB] no fire");
    applyStimulus(0, 99, 0, 99, 0, 16'h8888, 1'b1);
    checkOutput(0, 0);
    applyStimulus(1, 99, 0, 99, 0, 16'h7654, 1'b1);
    checkOutput(1, 0);

    $display("[TB] fire on last step");
    applyStimulus(0, 7, 2, 99, 0, 16'h3333, 1'b1);
    checkOutput(0, 0);
    applyStimulus(1, 7, 4, 99, 0, 16'h4444, 1'b1);
    checkOutput(1, 0);

    $display("[TB] later fire ignored");
    applyStimulus(0, 5, 5, 7, 1, 16'h5A5A, 1'b1);
    checkOutput(0, 0);
    applyStimulus(1, 5, 5, 7, 1, 16'hA5A5, 1'b1);
    checkOutput(1, 0);

    $display("[TB] backpressure");
    out_ready[0] = 1'b0;
    applyStimulus(0, 0, 7, 99, 0, 16'h0123, 1'b1);
    checkOutput(0, 6);
    applyStimulus(0, 3, 1, 99, 0, 16'h6543, 1'b1);
    checkOutput(0, 0);

    $display("[TB] reset mid-sweep");
    applyStimulus(0, 1, 4, 99, 0, 16'h5555, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkValue("midrst_in_ready", 32'(in_ready[0]),  32'd0);
      checkValue("midrst_valid",    32'(out_valid[0]), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    checkValue("postrst_in_ready", 32'(in_ready[0]),   32'd1);
    checkValue("postrst_time_val", 32'(time_val[0]),   32'd0);
    checkValue("postrst_winner",   32'(out_winner[0]), 32'd0);
    checkValue("postrst_out_time", 32'(out_time[0]),   32'd8);
    ones = 0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid[0]) ones++;
    end
    checkValue("postrst_no_result", 32'(ones), 32'd0);

    $display("[TB] recovery after reset");
    applyStimulus(1, 1, 2, 99, 0, 16'h2468, 1'b1);
    checkOutput(1, 0);
    applyStimulus(0, 6, 6, 99, 0, 16'h1357, 1'b1);
    checkOutput(0, 0);

    checkValue("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
